// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection phase controller:
// phase encoding, one-hot lamp codes, timer width and the traffic comparator.
package traffic_pkg;

   localparam int TMR_W = 6;

   typedef enum logic [2:0] {
      S_MG, S_MY, S_AR1, S_SG, S_SY, S_AR2, S_WALK
   } phase_e;

   // Lamp codes are one-hot {R,Y,G}
   localparam logic [2:0] LT_R = 3'b100;
   localparam logic [2:0] LT_Y = 3'b010;
   localparam logic [2:0] LT_G = 3'b001;

   typedef struct packed {
      logic m_gts;   // main level greater than side level
      logic m_lts;   // main level less than side level
   } traffic_cmp_t;

   function automatic traffic_cmp_t traffic_comp(input logic [2:0] main_lvl,
                                                 input logic [2:0] side_lvl);
      traffic_cmp_t cmp;
      cmp.m_gts = (main_lvl > side_lvl);
      cmp.m_lts = (main_lvl < side_lvl);
      return cmp;
   endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Sensor/button inputs and lamp-driver outputs of the phase controller.
// The master side drives sensors; the slave side is the controller itself.
interface traffic_phase_ctrl_if;

   logic       tick;
   logic       ped_btn;
   logic [2:0] main_traffic;
   logic [2:0] side_traffic;
   logic [2:0] main_light;
   logic [2:0] side_light;
   logic       walk;
   logic       ped_pending;
   logic       phase_tick;

   modport master (
      output tick, ped_btn, main_traffic, side_traffic,
      input  main_light, side_light, walk, ped_pending, phase_tick
   );

   modport slave (
      input  tick, ped_btn, main_traffic, side_traffic,
      output main_light, side_light, walk, ped_pending, phase_tick
   );

endinterface

// File: rtl/traffic_phase_ctrl_phase_timer.sv
// Loadable down-counter for phase duration; advances only on tick and
// flags zero so the controller knows the current phase has expired.
module phase_timer
   import traffic_pkg::*;
#(
   parameter logic [TMR_W-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_tick,
   input  logic             i_load,
   input  logic [TMR_W-1:0] i_load_val,
   output logic             o_zero
);

   logic [TMR_W-1:0] r_count;

   // NOTE: async reset in the sensitivity list, and <= for every state update so
   // all flops sample their inputs from before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= RESET_VAL;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_tick && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Intersection phase sequencer: explicit FSM over the light phases, green split
// chosen from traffic levels sampled at main-green entry, latched pedestrian service.
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int BASE_GREEN  = 12,
   parameter int EXTRA_GREEN = 4,
   parameter int YELLOW_T    = 2,
   parameter int ALL_RED_T   = 2,
   parameter int WALK_T      = 10
) (
   input  logic                 clk,
   input  logic                 reset,
   traffic_phase_ctrl_if.slave  bus
);

   localparam logic [TMR_W-1:0] LD_BASE  = TMR_W'(BASE_GREEN - 1);
   localparam logic [TMR_W-1:0] LD_LONG  = TMR_W'(BASE_GREEN + EXTRA_GREEN - 1);
   localparam logic [TMR_W-1:0] LD_YEL   = TMR_W'(YELLOW_T - 1);
   localparam logic [TMR_W-1:0] LD_AR    = TMR_W'(ALL_RED_T - 1);
   localparam logic [TMR_W-1:0] LD_WALK  = TMR_W'(WALK_T - 1);

   phase_e           r_state;
   phase_e           w_next_state;
   traffic_cmp_t     r_cmp;
   traffic_cmp_t     w_entry_cmp;
   logic             r_ped_pending;
   logic             r_phase_tick;
   logic             w_zero;
   logic             w_advance;
   logic [TMR_W-1:0] w_load_val;

   assign w_advance   = bus.tick && w_zero;
   assign w_entry_cmp = traffic_comp(bus.main_traffic, bus.side_traffic);

   phase_timer #(.RESET_VAL(LD_AR)) u_timer (
      .clk        (clk),
      .rst        (reset),
      .i_tick     (bus.tick),
      .i_load     (w_advance),
      .i_load_val (w_load_val),
      .o_zero     (w_zero)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_AR2;
      end else if (w_advance) begin
         r_state <= w_next_state;
      end
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_next_state = S_MG;
      case (r_state)
         S_MG:    w_next_state = S_MY;
         S_MY:    w_next_state = S_AR1;
         S_AR1:   w_next_state = S_SG;
         S_SG:    w_next_state = S_SY;
         S_SY:    w_next_state = S_AR2;
         S_AR2:   w_next_state = r_ped_pending ? S_WALK : S_MG;
         default: w_next_state = S_MG;
      endcase
   end

   // MG length uses the levels seen this clk, since they become the held compare
   always_comb begin
      w_load_val = LD_AR;
      case (w_next_state)
         S_MG:          w_load_val = w_entry_cmp.m_gts ? LD_LONG : LD_BASE;
         S_SG:          w_load_val = r_cmp.m_lts       ? LD_LONG : LD_BASE;
         S_MY, S_SY:    w_load_val = LD_YEL;
         S_WALK:        w_load_val = LD_WALK;
         default:       w_load_val = LD_AR;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cmp         <= '0;
         r_ped_pending <= 1'b0;
         r_phase_tick  <= 1'b0;
      end else begin
         r_phase_tick <= w_advance;
         if (w_advance && (w_next_state == S_MG)) begin
            r_cmp <= w_entry_cmp;
         end
         // Entering WALK clears the request even if the button is still pressed
         if (w_advance && (w_next_state == S_WALK)) begin
            r_ped_pending <= 1'b0;
         end else if (bus.ped_btn) begin
            r_ped_pending <= 1'b1;
         end
      end
   end

   always_comb begin
      bus.main_light = LT_R;
      bus.side_light = LT_R;
      bus.walk       = 1'b0;
      case (r_state)
         S_MG:    bus.main_light = LT_G;
         S_MY:    bus.main_light = LT_Y;
         S_SG:    bus.side_light = LT_G;
         S_SY:    bus.side_light = LT_Y;
         S_WALK:  bus.walk       = 1'b1;
         default: ;
      endcase
      bus.ped_pending = r_ped_pending;
      bus.phase_tick  = r_phase_tick;
   end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomized bench for traffic_phase_ctrl against a tick-counting phase model
// built from the phase order, durations and pedestrian rules.
module tb_traffic_phase_ctrl;

   localparam int BASE  = 12;
   localparam int EXTRA = 4;
   localparam int YEL   = 2;
   localparam int AR    = 2;
   localparam int WALKT = 10;

   // Model phase numbering: 0 MG, 1 MY, 2 AR1, 3 SG, 4 SY, 5 AR2, 6 WALK
   localparam int P_MG = 0, P_SG = 3, P_AR2 = 5, P_WALK = 6;

   logic clk = 1'b0;
   logic reset;

   traffic_phase_ctrl_if bus ();

   traffic_phase_ctrl #(
      .BASE_GREEN  (BASE),
      .EXTRA_GREEN (EXTRA),
      .YELLOW_T    (YEL),
      .ALL_RED_T   (AR),
      .WALK_T      (WALKT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   int m_phase;
   int m_elapsed;
   int m_cmp;
   bit m_pend;
   bit m_pt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic int dur(input int p, input int cmp);
      case (p)
         0:       return (cmp > 0) ? BASE + EXTRA : BASE;
         3:       return (cmp < 0) ? BASE + EXTRA : BASE;
         1, 4:    return YEL;
         6:       return WALKT;
         default: return AR;
      endcase
   endfunction

   function automatic int next_phase(input int p, input bit pend);
      if (p == P_AR2)  return pend ? P_WALK : P_MG;
      if (p == P_WALK) return P_MG;
      return p + 1;
   endfunction

   function automatic logic [10:0] exp_outs();
      logic [2:0] ml, sl;
      ml = (m_phase == 0) ? 3'b001 : (m_phase == 1) ? 3'b010 : 3'b100;
      sl = (m_phase == 3) ? 3'b001 : (m_phase == 4) ? 3'b010 : 3'b100;
      return {ml, sl, (m_phase == P_WALK), m_pend, m_pt};
   endfunction

   task automatic model_reset();
      m_phase   = P_AR2;
      m_elapsed = 0;
      m_cmp     = 0;
      m_pend    = 1'b0;
      m_pt      = 1'b0;
   endtask

   // One rising edge as seen by the model, using the inputs held across it
   task automatic model_clk();
      bit entering_walk;
      int np;
      entering_walk = 1'b0;
      m_pt = 1'b0;
      if (bus.tick) begin
         if (m_elapsed + 1 >= dur(m_phase, m_cmp)) begin
            np = next_phase(m_phase, m_pend);
            if (np == P_MG) begin
               m_cmp = (int'(bus.main_traffic) > int'(bus.side_traffic)) ?  1 :
                       (int'(bus.main_traffic) < int'(bus.side_traffic)) ? -1 : 0;
            end
            entering_walk = (np == P_WALK);
            m_phase   = np;
            m_elapsed = 0;
            m_pt      = 1'b1;
         end else begin
            m_elapsed++;
         end
      end
      m_pend = entering_walk ? 1'b0 : (m_pend | bus.ped_btn);
   endtask

   task automatic check_outs(input string tag);
      check(tag, {bus.main_light, bus.side_light, bus.walk, bus.ped_pending, bus.phase_tick},
            exp_outs());
   endtask

   // Called on a falling edge; drives inputs, crosses one rising edge, checks
   task automatic cycle(input bit t, input bit b, input logic [2:0] m, input logic [2:0] s);
      bus.tick         = t;
      bus.ped_btn      = b;
      bus.main_traffic = m;
      bus.side_traffic = s;
      @(posedge clk);
      model_clk();
      @(negedge clk);
      check_outs("outs");
   endtask

   // Fixed-level run; reports the last completed main/side green lengths in clks
   task automatic run_fixed(input int n, input int tper, input logic [2:0] m,
                            input logic [2:0] s, output int mg_len, output int sg_len);
      int cur_mg, cur_sg;
      cur_mg = 0; cur_sg = 0; mg_len = -1; sg_len = -1;
      for (int i = 0; i < n; i++) begin
         cycle((i % tper) == 0, 1'b0, m, s);
         if (bus.main_light == 3'b001) cur_mg++;
         else if (cur_mg > 0) begin mg_len = cur_mg; cur_mg = 0; end
         if (bus.side_light == 3'b001) cur_sg++;
         else if (cur_sg > 0) begin sg_len = cur_sg; cur_sg = 0; end
      end
   endtask

   initial begin
      int mg, sg;
      bit found;
      reset            = 1'b1;
      bus.tick         = 1'b0;
      bus.ped_btn      = 1'b0;
      bus.main_traffic = '0;
      bus.side_traffic = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check_outs("reset");
      reset = 1'b0;

      run_fixed(60, 1, 3'd5, 3'd2, mg, sg);
      check("mg_len_main_fav", mg, 16);
      check("sg_len_main_fav", sg, 12);

      run_fixed(120, 1, 3'd1, 3'd6, mg, sg);
      check("mg_len_side_fav", mg, 12);
      check("sg_len_side_fav", sg, 16);

      run_fixed(120, 1, 3'd3, 3'd3, mg, sg);
      check("mg_len_equal", mg, 12);
      check("sg_len_equal", sg, 12);

      for (int i = 0; i < 400; i++)
         cycle(1'b1, ($urandom_range(15) == 0), 3'($urandom), 3'($urandom));

      run_fixed(400, 4, 3'd5, 3'd2, mg, sg);
      check("mg_len_slow_tick", mg, 64);

      for (int i = 0; i < 100; i++)
         cycle(1'b0, 1'b0, 3'($urandom), 3'($urandom));

      for (int i = 0; i < 200; i++)
         cycle(1'b1, 1'b1, 3'($urandom), 3'($urandom));

      for (int i = 0; i < 1500; i++)
         cycle(1'($urandom), ($urandom_range(31) == 0), 3'($urandom), 3'($urandom));

      found = 1'b0;
      for (int i = 0; i < 500 && !found; i++) begin
         cycle(1'b1, 1'b1, 3'd3, 3'd3);
         found = (m_phase == P_SG) && m_pend;
      end
      check("wait_sg_pending", found, 1'b1);

      reset = 1'b1;
      model_reset();
      #1;
      check_outs("reset_mid_sg");
      check("reset_lamps", {bus.main_light, bus.side_light, bus.walk, bus.ped_pending},
            {3'b100, 3'b100, 1'b0, 1'b0});
      repeat (2) @(negedge clk);
      check_outs("reset_hold");
      reset = 1'b0;
      run_fixed(60, 1, 3'd5, 3'd2, mg, sg);
      check("mg_len_after_reset", mg, 16);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
